// File: rtl/db_pkg.sv
// Shared constants for the four-channel push-button debouncer.
// Channel indices map the named board buttons onto the internal channel vector.
package db_pkg;

    localparam int unsigned DB_CH            = 4;
    localparam int unsigned CH_HS            = 0;
    localparam int unsigned CH_VS            = 1;
    localparam int unsigned CH_DF_UART       = 2;
    localparam int unsigned CH_DF_VGA        = 3;
    localparam int unsigned DB_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/debounce_channel.sv
// Single-channel debouncer: the output follows the input only after LIMIT consecutive differing samples.
// Optional rising-edge pulse output when DB_PULSE_EN is defined.
module debounce_channel #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic out
`ifdef DB_PULSE_EN
    ,
    output logic rise
`endif
);

    localparam int unsigned CW      = (LIMIT < 2) ? 1 : $clog2(LIMIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(LIMIT - 1);

    logic          s_q, s_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;
`ifdef DB_PULSE_EN
    logic          rise_q, rise_d;
`endif

    // The sample flop doubles as the synchronizer; cnt tracks samples disagreeing with out.
    always_comb begin
        s_d   = btn;
        cnt_d = cnt_q;
        out_d = out_q;
        if (s_q == out_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            out_d = s_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
`ifdef DB_PULSE_EN
        rise_d = (s_q != out_q) && (cnt_q == CNT_MAX) && s_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q    <= 1'b0;
            cnt_q  <= '0;
            out_q  <= 1'b0;
`ifdef DB_PULSE_EN
            rise_q <= 1'b0;
`endif
        end else begin
            s_q    <= s_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
`ifdef DB_PULSE_EN
            rise_q <= rise_d;
`endif
        end
    end

    assign out = out_q;
`ifdef DB_PULSE_EN
    assign rise = rise_q;
`endif

endmodule

// File: rtl/button_debouncer.sv
// Four-channel push-button debouncer (HS, VS, DF_UART, DF_VGA) feeding UART/VGA control.
// Define DB_PULSE_EN to add the one-cycle rise_* pulse outputs.
module button_debouncer
    import db_pkg::*;
#(
    parameter int unsigned LIMIT = DB_LIMIT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btnHS,
    input  logic btnVS,
    input  logic btnDF_UART,
    input  logic btnDF_VGA,
    output logic HS,
    output logic VS,
    output logic DF_UART,
    output logic DF_VGA
`ifdef DB_PULSE_EN
    ,
    output logic rise_HS,
    output logic rise_VS,
    output logic rise_DF_UART,
    output logic rise_DF_VGA
`endif
);

    // A counter needs at least two states to filter anything.
    if (LIMIT < 2) begin : g_limit_check
        $error("button_debouncer: LIMIT must be >= 2");
    end

    logic [DB_CH-1:0] btn_vec;
    logic [DB_CH-1:0] out_vec;
`ifdef DB_PULSE_EN
    logic [DB_CH-1:0] rise_vec;
`endif

    assign btn_vec[CH_HS]      = btnHS;
    assign btn_vec[CH_VS]      = btnVS;
    assign btn_vec[CH_DF_UART] = btnDF_UART;
    assign btn_vec[CH_DF_VGA]  = btnDF_VGA;

    for (genvar g = 0; g < DB_CH; g++) begin : g_ch
        debounce_channel #(
            .LIMIT (LIMIT)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .btn   (btn_vec[g]),
            .out   (out_vec[g])
`ifdef DB_PULSE_EN
            ,
            .rise  (rise_vec[g])
`endif
        );
    end

    assign HS      = out_vec[CH_HS];
    assign VS      = out_vec[CH_VS];
    assign DF_UART = out_vec[CH_DF_UART];
    assign DF_VGA  = out_vec[CH_DF_VGA];
`ifdef DB_PULSE_EN
    assign rise_HS      = rise_vec[CH_HS];
    assign rise_VS      = rise_vec[CH_VS];
    assign rise_DF_UART = rise_vec[CH_DF_UART];
    assign rise_DF_VGA  = rise_vec[CH_DF_VGA];
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench: a window-based reference model predicts each edge's outputs, a monitor compares.
module tb_button_debouncer;
    import db_pkg::*;

    localparam int unsigned LIM = DB_LIMIT_DEFAULT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btnHS = 1'b1, btnVS = 1'b1, btnDF_UART = 1'b1, btnDF_VGA = 1'b1;
    logic HS, VS, DF_UART, DF_VGA;
`ifdef DB_PULSE_EN
    logic rise_HS, rise_VS, rise_DF_UART, rise_DF_VGA;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0] out;
        logic [3:0] rise;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    logic [3:0] m_out;
    logic [LIM-1:0] hist [DB_CH];

    always #5 clk = ~clk;

    button_debouncer #(.LIMIT(LIM)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btnHS      (btnHS),
        .btnVS      (btnVS),
        .btnDF_UART (btnDF_UART),
        .btnDF_VGA  (btnDF_VGA),
        .HS         (HS),
        .VS         (VS),
        .DF_UART    (DF_UART),
        .DF_VGA     (DF_VGA)
`ifdef DB_PULSE_EN
        ,
        .rise_HS      (rise_HS),
        .rise_VS      (rise_VS),
        .rise_DF_UART (rise_DF_UART),
        .rise_DF_VGA  (rise_DF_VGA)
`endif
    );

    function automatic logic [3:0] dut_out();
        return {DF_VGA, DF_UART, VS, HS};
    endfunction

`ifdef DB_PULSE_EN
    function automatic logic [3:0] dut_rise();
        return {rise_DF_VGA, rise_DF_UART, rise_VS, rise_HS};
    endfunction
`endif

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got=%b want=%b ({DF_VGA,DF_UART,VS,HS})", name, $time, got, want);
        end
    endtask

    // Reset leaves every sample register at 0, so the history window starts as all zeros.
    task automatic model_reset();
        m_out = '0;
        for (int c = 0; c < DB_CH; c++) hist[c] = '0;
    endtask

    // One clock of stimulus; the expected outputs after the coming edge are pushed for the monitor.
    // An output flips when the last LIM samples seen by the DUT all differ from it.
    task automatic step(input logic [3:0] b, input logic rn);
        exp_t e;
        @(negedge clk);
        rst_n = rn;
        {btnDF_VGA, btnDF_UART, btnVS, btnHS} = b;
        e.rise = '0;
        if (!rn) begin
            model_reset();
        end else begin
            for (int c = 0; c < DB_CH; c++) begin
                if (hist[c] == {LIM{~m_out[c]}}) begin
                    m_out[c]  = ~m_out[c];
                    e.rise[c] = m_out[c];
                end
                hist[c] = {hist[c][LIM-2:0], b[c]};
            end
        end
        e.out = m_out;
        sb_q.push_back(e);
    endtask

    task automatic hold(input logic [3:0] b, input int n);
        repeat (n) step(b, 1'b1);
    endtask

    // Monitor: compares DUT outputs after every edge for which a prediction exists.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                chk("out", dut_out(), mon_e.out);
`ifdef DB_PULSE_EN
                chk("rise", dut_rise(), mon_e.rise);
`endif
            end
        end
    end

    initial begin
        int first;
        logic [3:0] cur;
        logic [3:0] mask;
        logic [7:0] bounce;

        // Reset held with all buttons pressed.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", dut_out(), 4'b0000);
`ifdef DB_PULSE_EN
        chk("reset_rise", dut_rise(), 4'b0000);
`endif
        model_reset();

        // Release reset with btnHS held: HS must appear after the 5th edge, not earlier.
        first = 0;
        for (int k = 1; k <= 8; k++) begin
            step(4'b0001, 1'b1);
            @(posedge clk);
            #2;
            if (HS === 1'b1 && first == 0) first = k;
        end
        chk("hs_latency_edges", 4'(first), 4'd5);

        // Clean VS press.
        hold(4'b0001, 2);
        hold(4'b0011, 6);

        // DF_UART bounce that never reaches LIMIT, then a real press.
        bounce = 8'b0111_0111;
        for (int i = 7; i >= 0; i--) step({1'b0, bounce[i], 2'b11}, 1'b1);
        hold(4'b0111, 6);

        // DF_VGA press then release.
        hold(4'b1111, 6);
        hold(4'b0111, 7);

        // All released, then simultaneous press with one HS glitch.
        hold(4'b0000, 7);
        step(4'b1111, 1'b1);
        step(4'b1110, 1'b1);
        hold(4'b1111, 7);

        // Mid-count reset: VS high, HS counting, reset must clear everything at once.
        hold(4'b0010, 7);
        hold(4'b0011, 3);
        step(4'b0011, 1'b0);
        #1;
        chk("async_reset_out", dut_out(), 4'b0000);
        hold(4'b0011, 8);

        // Randomized bouncing buttons with occasional resets.
        cur = 4'b0000;
        for (int n = 0; n < 3000; n++) begin
            mask = '0;
            for (int c = 0; c < DB_CH; c++) mask[c] = ($urandom_range(0, 5) == 0);
            cur = cur ^ mask;
            step(cur, ($urandom_range(0, 299) != 0));
        end

        @(posedge clk);
        #2;
        chk("scoreboard_drained", 4'(sb_q.size()), 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
